// File: rtl/alu_result_stage.sv
// alu_result_stage: registered FIFO stage behind the 32-bit Alu.
// Captures {aluout, compout, masked overflow, op} behind a valid/ready
// handshake and keeps datapath-wide overflow status: a sticky flag, a
// saturating event counter and an optional trap that stalls intake.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] aluout,
  input  logic             compout,
  input  logic             overflow,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_comp,
  output logic             out_ovf,
  output logic [2:0]       out_op,
  input  logic             trap_en,
  input  logic             clr_status,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count,
  output logic             trap
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] OVF_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] OVF_MAX    = {CNT_W{1'b1}};

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } trap_state_t;

  trap_state_t       state;
  trap_state_t       state_nxt;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic [WIDTH-1:0]  data_mem [DEPTH];
  logic              comp_mem [DEPTH];
  logic              ovf_mem  [DEPTH];
  logic [2:0]        op_mem   [DEPTH];

  logic              movf;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ovf_event;

  // Handshake and status-event decode from registered state.
  assign movf      = overflow & ~unsig;
  assign full      = (count == COUNT_FULL);
  assign empty     = (count == '0);
  assign trap      = (state == TRAP);
  assign in_ready  = ~full & ~trap;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ovf_event = push & movf;

  // Head entry is presented straight from storage.
  assign out_data = data_mem[rd_ptr];
  assign out_comp = comp_mem[rd_ptr];
  assign out_ovf  = ovf_mem[rd_ptr];
  assign out_op   = op_mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage, written at the write pointer on each push.
  // NOTE: storage is reset so the head outputs read 0 after reset; with
  // only DEPTH entries the reset cost is small and the outputs are defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        comp_mem[i] <= 1'b0;
        ovf_mem[i]  <= 1'b0;
        op_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= aluout;
      comp_mem[wr_ptr] <= compout;
      ovf_mem[wr_ptr]  <= movf;
      op_mem[wr_ptr]   <= op;
    end
  end

  // Sticky overflow flag; a new overflow wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (ovf_event) begin
      sticky_ovf <= 1'b1;
    end else if (clr_status) begin
      sticky_ovf <= 1'b0;
    end
  end

  // Saturating overflow counter; clear plus increment yields 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_event) begin
      if (clr_status) begin
        ovf_count <= OVF_ONE;
      end else if (ovf_count != OVF_MAX) begin
        ovf_count <= ovf_count + OVF_ONE;
      end
    end else if (clr_status) begin
      ovf_count <= '0;
    end
  end

  // Trap state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Trap next-state: enter on a trapping overflow push, leave on clear.
  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (ovf_event && trap_en) state_nxt = TRAP;
      TRAP:    if (clr_status)           state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed testbench for alu_result_stage: a table of single-cycle vectors
// followed by hand-written sequences for fill/drain, trap, saturation and
// asynchronous reset.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] aluout;
  logic        compout;
  logic        overflow;
  logic [2:0]  op;
  logic        unsig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_comp;
  logic        out_ovf;
  logic [2:0]  out_op;
  logic        trap_en;
  logic        clr_status;
  logic        sticky_ovf;
  logic [7:0]  ovf_count;
  logic        trap;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .aluout     (aluout),
    .compout    (compout),
    .overflow   (overflow),
    .op         (op),
    .unsig      (unsig),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_comp   (out_comp),
    .out_ovf    (out_ovf),
    .out_op     (out_op),
    .trap_en    (trap_en),
    .clr_status (clr_status),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count),
    .trap       (trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        c;
    logic        o;
    logic [2:0]  op;
    logic        u;
    logic        ordy;
    logic        ten;
    logic        clr;
    logic        e_ov;
    logic [31:0] e_d;
    logic        e_c;
    logic        e_o;
    logic [2:0]  e_op;
    logic        e_ir;
    logic        e_st;
    logic [7:0]  e_cnt;
    logic        e_tr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic c,
                       input logic o, input logic [2:0] opc, input logic u);
    in_valid = iv;
    aluout   = d;
    compout  = c;
    overflow = o;
    op       = opc;
    unsig    = u;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    trap_en    = 1'b0;
    clr_status = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Vector table: inputs for one cycle, expected outputs after that edge.
    //          iv  data          c  o  op    u  ordy ten clr | ov  data          c  o  op    ir st cnt tr
    vecs[0] = '{1, 32'hFFFFFFFE, 1, 1, 3'd2, 0, 0,   0,  0,   1,  32'hFFFFFFFE, 1, 1, 3'd2, 1, 1, 8'd1, 0};
    vecs[1] = '{0, 32'h00000000, 0, 0, 3'd0, 0, 1,   0,  1,   0,  32'h00000000, 0, 0, 3'd0, 1, 0, 8'd0, 0};
    vecs[2] = '{1, 32'hFFFFFFFE, 0, 1, 3'd2, 1, 0,   0,  0,   1,  32'hFFFFFFFE, 0, 0, 3'd2, 1, 0, 8'd0, 0};
    vecs[3] = '{1, 32'h12345678, 1, 0, 3'd5, 0, 1,   0,  0,   1,  32'h12345678, 1, 0, 3'd5, 1, 0, 8'd0, 0};
    vecs[4] = '{0, 32'h00000000, 0, 0, 3'd0, 0, 1,   0,  0,   0,  32'h00000000, 0, 0, 3'd0, 1, 0, 8'd0, 0};

    // Reset state.
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_status", {sticky_ovf, ovf_count, trap}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Table-driven single-cycle vectors.
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].o, vecs[i].op, vecs[i].u);
      out_ready  = vecs[i].ordy;
      trap_en    = vecs[i].ten;
      clr_status = vecs[i].clr;
      tick();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_d);
      check($sformatf("v%0d_out_comp", i), out_comp, vecs[i].e_c);
      check($sformatf("v%0d_out_ovf", i), out_ovf, vecs[i].e_o);
      check($sformatf("v%0d_out_op", i), out_op, vecs[i].e_op);
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("v%0d_sticky", i), sticky_ovf, vecs[i].e_st);
      check($sformatf("v%0d_count", i), ovf_count, vecs[i].e_cnt);
      check($sformatf("v%0d_trap", i), trap, vecs[i].e_tr);
    end
    clr_status = 1'b0;

    // Fill to full with the consumer stalled; ready drops after the 4th push.
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0, 3'd1, 1'b0);
      tick();
      check($sformatf("fill%0d_in_ready", i), in_ready, (i < 4) ? 1 : 0);
    end
    drive(1'b1, 32'd5, 1'b0, 1'b0, 3'd1, 1'b0);
    tick();
    check("full_ignored_head", out_data, 1);
    check("full_ignored_ready", in_ready, 0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d_valid", i), out_valid, 1);
      check($sformatf("drain%0d_data", i), out_data, 32'(i));
      tick();
    end
    check("drain_empty", out_valid, 0);
    check("drain_in_ready", in_ready, 1);

    // Trap: stalls intake, output still drains, trap_en drop keeps it.
    out_ready = 1'b0;
    trap_en   = 1'b1;
    drive(1'b1, 32'hAA, 1'b0, 1'b1, 3'd3, 1'b0);
    tick();
    check("trap_set", trap, 1);
    check("trap_in_ready", in_ready, 0);
    check("trap_entry_stored", out_data, 32'hAA);
    check("trap_count", ovf_count, 1);
    trap_en   = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hBB, 1'b0, 1'b0, 3'd3, 1'b0);
    tick();
    check("trap_drained", out_valid, 0);
    check("trap_held", trap, 1);
    check("trap_still_stalled", in_ready, 0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_trap", trap, 0);
    check("clr_sticky", sticky_ovf, 0);
    check("clr_count", ovf_count, 0);
    check("clr_in_ready", in_ready, 1);
    check("clr_no_entry", out_valid, 0);

    // Saturation: 300 overflow pushes with continuous draining.
    out_ready = 1'b1;
    drive(1'b1, 32'h7, 1'b0, 1'b1, 3'd2, 1'b0);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 100) check("sat_count_100", ovf_count, 100);
      if (i == 254) check("sat_count_254", ovf_count, 254);
    end
    check("sat_count", ovf_count, 255);
    check("sat_in_ready", in_ready, 1);
    // Clear together with an overflow push yields 1, sticky stays set.
    clr_status = 1'b1;
    tick();
    check("clr_inc_count", ovf_count, 1);
    check("clr_inc_sticky", sticky_ovf, 1);
    // Trap set wins over a same-cycle clear.
    trap_en = 1'b1;
    tick();
    check("trap_set_wins", trap, 1);
    check("trap_clr_inc_count", ovf_count, 1);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    trap_en = 1'b0;
    tick();
    clr_status = 1'b0;
    check("trap_cleared_again", trap, 0);

    // Reset mid-operation with three entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 1'b1, 1'b1, 3'd7, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    check("pre_rst_head", out_data, 32'h11);
    check("pre_rst_count", ovf_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_fields", {out_data, out_comp, out_ovf, out_op}, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_status", {sticky_ovf, ovf_count, trap}, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_arst_empty", out_valid, 0);
    check("post_arst_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
